// File: rtl/ext_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ext_mem_arbiter                                               |
// | Brief    : Round-robin arbiter sharing one line-fill bus between I$/D$.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module ext_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 512,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_addr_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  output logic                  req0_data_ready,
  output logic [LINE_WIDTH-1:0] req0_data,
  output logic                  req0_err,

  input  logic                  req1_addr_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic                  req1_data_ready,
  output logic [LINE_WIDTH-1:0] req1_data,
  output logic                  req1_err,

  output logic                  mem_addr_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_data_ready,
  input  logic [LINE_WIDTH-1:0] mem_data_i,

  output logic [1:0]            grant
);

  localparam int               CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic             c_TMO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_addr_valid, w_addr_valid_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [1:0]            r_grant, w_grant_nxt;
  logic                  r_last, w_last_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [LINE_WIDTH-1:0] r_data0, w_data0_nxt;
  logic [LINE_WIDTH-1:0] r_data1, w_data1_nxt;
  logic                  r_rdy0, w_rdy0_nxt;
  logic                  r_rdy1, w_rdy1_nxt;
  logic                  r_err0, w_err0_nxt;
  logic                  r_err1, w_err1_nxt;
  logic                  w_win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_addr_valid <= 1'b0;
      r_addr       <= '0;
      r_grant      <= 2'b00;
      r_last       <= 1'b1;
      r_cnt        <= '0;
      r_data0      <= '0;
      r_data1      <= '0;
      r_rdy0       <= 1'b0;
      r_rdy1       <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr_valid <= w_addr_valid_nxt;
      r_addr       <= w_addr_nxt;
      r_grant      <= w_grant_nxt;
      r_last       <= w_last_nxt;
      r_cnt        <= w_cnt_nxt;
      r_data0      <= w_data0_nxt;
      r_data1      <= w_data1_nxt;
      r_rdy0       <= w_rdy0_nxt;
      r_rdy1       <= w_rdy1_nxt;
      r_err0       <= w_err0_nxt;
      r_err1       <= w_err1_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_addr_valid_nxt = r_addr_valid;
    w_addr_nxt       = r_addr;
    w_grant_nxt      = r_grant;
    w_last_nxt       = r_last;
    w_cnt_nxt        = r_cnt;
    w_data0_nxt      = r_data0;
    w_data1_nxt      = r_data1;
    w_rdy0_nxt       = 1'b0;
    w_rdy1_nxt       = 1'b0;
    w_err0_nxt       = 1'b0;
    w_err1_nxt       = 1'b0;
    w_win            = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (req0_addr_valid || req1_addr_valid) begin
          // w_win is the winning port index; on a conflict the port not served last wins
          w_win            = (req0_addr_valid && req1_addr_valid) ? ~r_last : req1_addr_valid;
          w_addr_nxt       = w_win ? req1_addr : req0_addr;
          w_grant_nxt      = w_win ? 2'b10 : 2'b01;
          w_last_nxt       = w_win;
          w_addr_valid_nxt = 1'b1;
          w_cnt_nxt        = '0;
          w_state_nxt      = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (mem_data_ready) begin
          if (r_grant[1]) begin
            w_data1_nxt = mem_data_i;
            w_rdy1_nxt  = 1'b1;
          end else begin
            w_data0_nxt = mem_data_i;
            w_rdy0_nxt  = 1'b1;
          end
          w_addr_valid_nxt = 1'b0;
          w_state_nxt      = S_RELEASE;
        end else if (c_TMO_EN && (r_cnt == c_TMO_LAST)) begin
          if (r_grant[1]) begin
            w_data1_nxt = '0;
            w_rdy1_nxt  = 1'b1;
            w_err1_nxt  = 1'b1;
          end else begin
            w_data0_nxt = '0;
            w_rdy0_nxt  = 1'b1;
            w_err0_nxt  = 1'b1;
          end
          w_addr_valid_nxt = 1'b0;
          w_state_nxt      = S_RELEASE;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end

      S_RELEASE: begin
        // a combinational responder may still be high from the previous request
        if (!mem_data_ready) begin
          w_grant_nxt = 2'b00;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt      = S_IDLE;
        w_addr_valid_nxt = 1'b0;
        w_grant_nxt      = 2'b00;
      end
    endcase
  end

  assign mem_addr_valid  = r_addr_valid;
  assign mem_addr        = r_addr;
  assign grant           = r_grant;
  assign req0_data       = r_data0;
  assign req1_data       = r_data1;
  assign req0_data_ready = r_rdy0;
  assign req1_data_ready = r_rdy1;
  assign req0_err        = r_err0;
  assign req1_err        = r_err1;

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ext_mem_arbiter                                            |
// | Brief    : Directed scoreboard bench for ext_mem_arbiter.                |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_ext_mem_arbiter;

  localparam int AW  = 32;
  localparam int LW  = 512;
  localparam int TMO = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_addr_valid, req1_addr_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic          req0_data_ready, req1_data_ready;
  logic [LW-1:0] req0_data, req1_data;
  logic          req0_err, req1_err;
  logic          mem_addr_valid;
  logic [AW-1:0] mem_addr;
  logic          mem_data_ready;
  logic [LW-1:0] mem_data_i;
  logic [1:0]    grant;

  // responder model knobs
  logic resp_en, force_hi, fixed_a5;
  int   lat;
  int   valid_cnt = 0;
  int   cyc = 0;

  int   n_pass = 0;
  int   n_fail = 0;
  int   pulses0 = 0;
  int   pulses1 = 0;
  int   grant_cyc = 0;
  int   done_cyc = 0;
  logic [1:0] prev_g = 2'b00;
  logic pr0 = 1'b0;
  logic pr1 = 1'b0;

  exp_t       exp0[$], exp1[$], pend0[$], pend1[$];
  logic [1:0] grant_log[$];
  int         done_log[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    valid_cnt <= mem_addr_valid ? valid_cnt + 1 : 0;
  end

  assign mem_data_ready = force_hi | (resp_en & mem_addr_valid & (valid_cnt >= lat));
  assign mem_data_i     = fixed_a5 ? {64{8'hA5}} : {16{mem_addr ^ 32'h5A5A_0F0F}};

  ext_mem_arbiter #(
    .ADDR_WIDTH (AW),
    .LINE_WIDTH (LW),
    .TIMEOUT    (TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req0_addr_valid (req0_addr_valid),
    .req0_addr       (req0_addr),
    .req0_data_ready (req0_data_ready),
    .req0_data       (req0_data),
    .req0_err        (req0_err),
    .req1_addr_valid (req1_addr_valid),
    .req1_addr       (req1_addr),
    .req1_data_ready (req1_data_ready),
    .req1_data       (req1_data),
    .req1_err        (req1_err),
    .mem_addr_valid  (mem_addr_valid),
    .mem_addr        (mem_addr),
    .mem_data_ready  (mem_data_ready),
    .mem_data_i      (mem_data_i),
    .grant           (grant)
  );

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    return fixed_a5 ? {64{8'hA5}} : {16{a ^ 32'h5A5A_0F0F}};
  endfunction

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic request(input int p, input logic [AW-1:0] a, input logic e);
    exp_t x;
    x.addr = a;
    x.err  = e;
    x.data = e ? '0 : line_of(a);
    if (p == 0) begin
      if (!req0_addr_valid) begin
        req0_addr = a; req0_addr_valid = 1'b1; exp0.push_back(x);
      end else pend0.push_back(x);
    end else begin
      if (!req1_addr_valid) begin
        req1_addr = a; req1_addr_valid = 1'b1; exp1.push_back(x);
      end else pend1.push_back(x);
    end
  endtask

  // Pop and compare the expected line; the requester then loads its next pending address.
  task automatic serve(input int p);
    exp_t x;
    done_cyc = cyc;
    done_log.push_back(p);
    if (p == 0) begin
      pulses0++;
      chk("rdy0_outstanding", (exp0.size() != 0), 1'b1);
      if (exp0.size() != 0) begin
        x = exp0.pop_front();
        chk("data0", req0_data, x.data);
        chk("err0", req0_err, x.err);
      end
      if (pend0.size() != 0) begin
        x = pend0.pop_front(); req0_addr = x.addr; exp0.push_back(x);
      end else req0_addr_valid = 1'b0;
    end else begin
      pulses1++;
      chk("rdy1_outstanding", (exp1.size() != 0), 1'b1);
      if (exp1.size() != 0) begin
        x = exp1.pop_front();
        chk("data1", req1_data, x.data);
        chk("err1", req1_err, x.err);
      end
      if (pend1.size() != 0) begin
        x = pend1.pop_front(); req1_addr = x.addr; exp1.push_back(x);
      end else req1_addr_valid = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (grant !== prev_g) begin
        grant_log.push_back(grant);
        if (grant != 2'b00) grant_cyc = cyc;
        prev_g = grant;
      end
      if (pr0) chk("rdy0_single_cycle", req0_data_ready, 1'b0);
      if (pr1) chk("rdy1_single_cycle", req1_data_ready, 1'b0);
      if (req0_err) chk("err0_with_rdy", req0_data_ready, 1'b1);
      if (req1_err) chk("err1_with_rdy", req1_data_ready, 1'b1);
      if (req0_data_ready) serve(0);
      if (req1_data_ready) serve(1);
      pr0 = req0_data_ready;
      pr1 = req1_data_ready;
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (n < budget && !(exp0.size() == 0 && exp1.size() == 0 && pend0.size() == 0 &&
                           pend1.size() == 0 && grant == 2'b00)) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", (n < budget), 1'b1);
  endtask

  task automatic wait_pulse(input int p, input int target, input int budget);
    int n = 0;
    while (n < budget && ((p == 0 ? pulses0 : pulses1) < target)) begin
      @(negedge clk);
      n++;
    end
    chk("pulse_within_budget", (n < budget), 1'b1);
  endtask

  task automatic clear_tb();
    req0_addr_valid = 1'b0;
    req1_addr_valid = 1'b0;
    exp0.delete(); exp1.delete(); pend0.delete(); pend1.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_tb();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_addr_valid"}, mem_addr_valid, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, '0);
    chk({tag, "_grant"}, grant, 2'b00);
    chk({tag, "_rdy0"}, req0_data_ready, 1'b0);
    chk({tag, "_rdy1"}, req1_data_ready, 1'b0);
    chk({tag, "_err0"}, req0_err, 1'b0);
    chk({tag, "_err1"}, req1_err, 1'b0);
    chk({tag, "_data0"}, req0_data, '0);
    chk({tag, "_data1"}, req1_data, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, p1, req_cyc;
    logic [1:0] g_exp[4];
    rst = 1'b0;
    req0_addr = '0;
    req1_addr = '0;
    req0_addr_valid = 1'b0;
    req1_addr_valid = 1'b0;
    resp_en = 1'b1; force_hi = 1'b0; fixed_a5 = 1'b0; lat = 1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // single requester on port 0, responder one cycle late, fixed A5 line
    fixed_a5 = 1'b1;
    request(0, 32'h0000_0040, 1'b0);
    @(negedge clk);
    chk("t1_addr_valid", mem_addr_valid, 1'b1);
    chk("t1_mem_addr", mem_addr, 32'h0000_0040);
    chk("t1_grant", grant, 2'b01);
    wait_idle(50);
    chk("t1_pulses0", pulses0, 1);
    chk("t1_pulses1", pulses1, 0);
    chk("t1_data0", req0_data, {64{8'hA5}});
    fixed_a5 = 1'b0;

    // simultaneous conflict right after reset: port 0 first
    do_reset();
    grant_log.delete();
    done_log.delete();
    request(0, 32'h0000_0100, 1'b0);
    request(1, 32'h8000_0000, 1'b0);
    wait_idle(80);
    g_exp = '{2'b01, 2'b00, 2'b10, 2'b00};
    chk("t2_done_count", done_log.size(), 2);
    if (done_log.size() >= 2) begin
      chk("t2_first_port", done_log[0], 0);
      chk("t2_second_port", done_log[1], 1);
    end
    chk("t2_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("t2_grant_seq", grant_log[i], g_exp[i]);

    // both ports held requesting for six transactions
    done_log.delete();
    for (int k = 0; k < 3; k++) begin
      request(0, 32'h0000_1000 + 32'(k * 64), 1'b0);
      request(1, 32'h0000_2000 + 32'(k * 64), 1'b0);
    end
    wait_idle(200);
    chk("t3_done_count", done_log.size(), 6);
    for (int i = 0; i < 6 && i < done_log.size(); i++) chk("t3_alternate", done_log[i], i % 2);

    // timeout on port 1 with silent responder
    resp_en = 1'b0;
    p1 = pulses1;
    request(1, 32'h1234_5600, 1'b1);
    wait_pulse(1, p1 + 1, 40);
    chk("t4_latency", done_cyc - grant_cyc, TMO);
    repeat (2) @(negedge clk);
    chk("t4_grant_idle", grant, 2'b00);
    chk("t4_addr_valid_low", mem_addr_valid, 1'b0);
    chk("t4_data1_zero", req1_data, '0);
    resp_en = 1'b1;

    // zero-wait combinational responder
    lat = 0;
    request(0, 32'h0000_0200, 1'b0);
    req_cyc = cyc;
    wait_idle(40);
    chk("t5_zero_wait_latency", done_cyc - req_cyc, 2);

    // mem_data_ready held high after completion: stays in RELEASE
    force_hi = 1'b1;
    p1 = pulses1;
    request(1, 32'h0000_0300, 1'b0);
    wait_pulse(1, p1 + 1, 20);
    p0 = pulses0;
    request(0, 32'h0000_0400, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("t5_hold_grant", grant, 2'b10);
      chk("t5_hold_addr_valid", mem_addr_valid, 1'b0);
    end
    chk("t5_no_dup_pulse", pulses1, p1 + 1);
    chk("t5_no_new_grant", pulses0, p0);
    force_hi = 1'b0;
    wait_idle(40);
    chk("t5_after_release", pulses0, p0 + 1);

    // asynchronous reset in the middle of ISSUE
    resp_en = 1'b0;
    lat = 1;
    request(0, 32'h0000_0500, 1'b0);
    repeat (3) @(negedge clk);
    chk("t6_in_issue", grant, 2'b01);
    p0 = pulses0;
    #2 rst = 1'b0;
    #1 chk_all_zero("t6_async");
    clear_tb();
    repeat (2) @(negedge clk);
    chk("t6_no_completion", pulses0, p0);
    rst = 1'b1;
    resp_en = 1'b1;
    @(negedge clk);
    done_log.delete();
    request(1, 32'h0000_0700, 1'b0);
    request(0, 32'h0000_0600, 1'b0);
    wait_idle(80);
    chk("t6_done_count", done_log.size(), 2);
    if (done_log.size() >= 1) chk("t6_port0_wins", done_log[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
`default_nettype wire
